// File: rtl/hazard_control_unit_pkg.sv
// Shared definitions for the pipeline hazard/sequencing unit.
package hazard_control_unit_pkg;

  localparam int DEF_REG_AW      = 3;
  localparam int DEF_STACK_WORDS = 2;
  localparam int DEF_CNT_W       = 1;

  // PC source select encodings
  localparam logic [1:0] PC_SEL_SEQ = 2'b00;  // PC+1
  localparam logic [1:0] PC_SEL_JMP = 2'b01;  // EX jump target
  localparam logic [1:0] PC_SEL_MEM = 2'b10;  // memory data (RET/RTI)
  localparam logic [1:0] PC_SEL_VEC = 2'b11;  // interrupt vector

  // Winning pipeline event for a cycle, in priority order
  typedef enum logic [2:0] {
    EV_NONE,
    EV_FREEZE,
    EV_LAST,
    EV_JUMP,
    EV_LOAD_USE,
    EV_INT
  } hz_event_t;

  typedef struct packed {
    logic       pc_en;
    logic       if_id_en;
    logic       if_id_flush;
    logic       id_ex_en;
    logic       id_ex_bubble;
    logic       ex_mem_en;
    logic       ex_mem_bubble;
    logic [1:0] pc_sel;
    logic       int_inject;
    logic       int_ack;
  } pipe_ctrl_t;

  // Normal advance: everything enabled, nothing flushed, sequential PC
  function automatic pipe_ctrl_t ctrl_advance();
    pipe_ctrl_t c;
    c.pc_en         = 1'b1;
    c.if_id_en      = 1'b1;
    c.if_id_flush   = 1'b0;
    c.id_ex_en      = 1'b1;
    c.id_ex_bubble  = 1'b0;
    c.ex_mem_en     = 1'b1;
    c.ex_mem_bubble = 1'b0;
    c.pc_sel        = PC_SEL_SEQ;
    c.int_inject    = 1'b0;
    c.int_ack       = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// Pipeline-side signals of the hazard unit: stage status in, buffer controls out.
interface hazard_control_unit_if #(
  parameter int REG_AW = 3,
  parameter int CNT_W  = 1
);
  logic [REG_AW-1:0] id_src1_addr;
  logic              id_src1_used;
  logic [REG_AW-1:0] id_src2_addr;
  logic              id_src2_used;
  logic              ex_mr;
  logic              ex_wb;
  logic [REG_AW-1:0] ex_wb_addr;
  logic              ex_taken_jump;
  logic              mem_stack_pc;
  logic              mem_stack_flg;
  logic              mem_jwsp;
  logic              int_req;

  logic              pc_en;
  logic              if_id_en;
  logic              if_id_flush;
  logic              id_ex_en;
  logic              id_ex_bubble;
  logic              ex_mem_en;
  logic              ex_mem_bubble;
  logic [1:0]        pc_sel;
  logic [CNT_W-1:0]  mem_word_sel;
  logic              int_inject;
  logic              int_ack;

  // Pipeline datapath side
  modport master (
    output id_src1_addr, id_src1_used, id_src2_addr, id_src2_used,
           ex_mr, ex_wb, ex_wb_addr, ex_taken_jump,
           mem_stack_pc, mem_stack_flg, mem_jwsp, int_req,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble,
           ex_mem_en, ex_mem_bubble, pc_sel, mem_word_sel, int_inject, int_ack
  );

  // Hazard unit side
  modport slave (
    input  id_src1_addr, id_src1_used, id_src2_addr, id_src2_used,
           ex_mr, ex_wb, ex_wb_addr, ex_taken_jump,
           mem_stack_pc, mem_stack_flg, mem_jwsp, int_req,
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble,
           ex_mem_en, ex_mem_bubble, pc_sel, mem_word_sel, int_inject, int_ack
  );
endinterface

// File: rtl/hazard_control_unit_stack_word_counter.sv
// Tracks which 16-bit word of a multi-word Stack_PC access is in MEM.
module hazard_control_unit_stack_word_counter #(
  parameter int STACK_WORDS = 2,
  parameter int CNT_W       = 1
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             stack_pc,
  output logic [CNT_W-1:0] word_cnt,
  output logic             freeze,
  output logic             last_word
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STACK_WORDS - 1);

  // Not on the last word yet: hold the pipe; on the last word: let it go
  always_comb begin
    freeze    = stack_pc && (word_cnt != LAST);
    last_word = stack_pc && (word_cnt == LAST);
  end

  // Step through the words, wrapping back to 0 only after the last one
  always_ff @(posedge clk) begin
    if (rst)            word_cnt <= '0;
    else if (freeze)    word_cnt <= word_cnt + 1'b1;
    else if (last_word) word_cnt <= '0;
  end
endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencer: stalls, flushes, PC redirect and interrupt injection.
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int REG_AW      = DEF_REG_AW,
  parameter int STACK_WORDS = DEF_STACK_WORDS,
  parameter int CNT_W       = DEF_CNT_W
)(
  input logic                 clk,
  input logic                 rst,
  hazard_control_unit_if.slave bus
);
  logic [CNT_W-1:0]  word_cnt;
  logic              freeze, last_word;
  logic              int_pending, int_inflight;
  logic              load_use;
  logic [REG_AW-1:0] wb_addr;
  hz_event_t         ev;
  pipe_ctrl_t        ctrl;

  hazard_control_unit_stack_word_counter #(
    .STACK_WORDS (STACK_WORDS),
    .CNT_W       (CNT_W)
  ) u_word_cnt (
    .clk       (clk),
    .rst       (rst),
    .stack_pc  (bus.mem_stack_pc),
    .word_cnt  (word_cnt),
    .freeze    (freeze),
    .last_word (last_word)
  );

  assign wb_addr = bus.ex_wb_addr;

  // Load in EX whose destination is read by the instruction in decode
  always_comb begin
    load_use = bus.ex_mr && bus.ex_wb &&
               ((bus.id_src1_used && (bus.id_src1_addr == wb_addr)) ||
                (bus.id_src2_used && (bus.id_src2_addr == wb_addr)));
  end

  // Pick the single highest-priority event; lower ones are dropped this cycle
  always_comb begin
    ev = EV_NONE;
    if (freeze)                            ev = EV_FREEZE;
    else if (last_word)                    ev = EV_LAST;
    else if (bus.ex_taken_jump)            ev = EV_JUMP;
    else if (load_use)                     ev = EV_LOAD_USE;
    else if (int_pending && !int_inflight) ev = EV_INT;
  end

  // Translate the event (or reset) into buffer enables/flushes and PC select
  always_comb begin
    ctrl = ctrl_advance();
    if (rst) begin
      ctrl.if_id_flush   = 1'b1;
      ctrl.id_ex_bubble  = 1'b1;
      ctrl.ex_mem_bubble = 1'b1;
    end else begin
      case (ev)
        EV_FREEZE: begin
          ctrl.pc_en     = 1'b0;
          ctrl.if_id_en  = 1'b0;
          ctrl.id_ex_en  = 1'b0;
          ctrl.ex_mem_en = 1'b0;
        end
        EV_LAST: begin
          if (bus.mem_jwsp) begin
            ctrl.pc_sel        = PC_SEL_MEM;
            ctrl.if_id_flush   = 1'b1;
            ctrl.id_ex_bubble  = 1'b1;
            ctrl.ex_mem_bubble = 1'b1;
          end
        end
        EV_JUMP: begin
          ctrl.pc_sel       = PC_SEL_JMP;
          ctrl.if_id_flush  = 1'b1;
          ctrl.id_ex_bubble = 1'b1;
        end
        EV_LOAD_USE: begin
          ctrl.pc_en        = 1'b0;
          ctrl.if_id_en     = 1'b0;
          ctrl.id_ex_bubble = 1'b1;
        end
        EV_INT: begin
          // PC is held so the INT op pushes the interrupted address
          ctrl.pc_en      = 1'b0;
          ctrl.int_inject = 1'b1;
          ctrl.int_ack    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Interrupt flags: latch one request, hold it in flight until RTI retires
  always_ff @(posedge clk) begin
    if (rst) begin
      int_pending  <= 1'b0;
      int_inflight <= 1'b0;
    end else begin
      if (ev == EV_INT) begin
        int_pending  <= 1'b0;
        int_inflight <= 1'b1;
      end else if (bus.int_req && !int_pending && !int_inflight) begin
        int_pending <= 1'b1;
      end
      if ((ev == EV_LAST) && bus.mem_stack_flg && int_inflight)
        int_inflight <= 1'b0;
    end
  end

  assign bus.pc_en         = ctrl.pc_en;
  assign bus.if_id_en      = ctrl.if_id_en;
  assign bus.if_id_flush   = ctrl.if_id_flush;
  assign bus.id_ex_en      = ctrl.id_ex_en;
  assign bus.id_ex_bubble  = ctrl.id_ex_bubble;
  assign bus.ex_mem_en     = ctrl.ex_mem_en;
  assign bus.ex_mem_bubble = ctrl.ex_mem_bubble;
  assign bus.pc_sel        = ctrl.pc_sel;
  assign bus.int_inject    = ctrl.int_inject;
  assign bus.int_ack       = ctrl.int_ack;
  assign bus.mem_word_sel  = rst ? '0 : word_cnt;
endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: directed scenarios plus random traffic.
module tb_hazard_control_unit;
  import hazard_control_unit_pkg::*;

  localparam int SW    = 2;
  localparam int CNT_W = 1;

  typedef struct packed {
    pipe_ctrl_t       c;
    logic [CNT_W-1:0] mws;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_control_unit_if #(.REG_AW(3), .CNT_W(CNT_W)) bus_if ();

  hazard_control_unit #(.REG_AW(3), .STACK_WORDS(SW), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  int   n_chk = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  exp_t obs;
  int   m_cnt  = 0;
  bit   m_pend = 0;
  bit   m_infl = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference behaviour computed from the current inputs and model state
  function automatic exp_t model();
    exp_t e;
    bit   lu;
    e.c   = ctrl_advance();
    e.mws = rst ? '0 : CNT_W'(m_cnt);
    lu = bus_if.ex_mr && bus_if.ex_wb &&
         ((bus_if.id_src1_used && bus_if.id_src1_addr == bus_if.ex_wb_addr) ||
          (bus_if.id_src2_used && bus_if.id_src2_addr == bus_if.ex_wb_addr));
    if (rst) begin
      e.c.if_id_flush = 1; e.c.id_ex_bubble = 1; e.c.ex_mem_bubble = 1;
    end else if (bus_if.mem_stack_pc && m_cnt != SW - 1) begin
      e.c.pc_en = 0; e.c.if_id_en = 0; e.c.id_ex_en = 0; e.c.ex_mem_en = 0;
    end else if (bus_if.mem_stack_pc) begin
      if (bus_if.mem_jwsp) begin
        e.c.pc_sel = 2'b10; e.c.if_id_flush = 1; e.c.id_ex_bubble = 1; e.c.ex_mem_bubble = 1;
      end
    end else if (bus_if.ex_taken_jump) begin
      e.c.pc_sel = 2'b01; e.c.if_id_flush = 1; e.c.id_ex_bubble = 1;
    end else if (lu) begin
      e.c.pc_en = 0; e.c.if_id_en = 0; e.c.id_ex_bubble = 1;
    end else if (m_pend && !m_infl) begin
      e.c.pc_en = 0; e.c.int_inject = 1; e.c.int_ack = 1;
    end
    return e;
  endfunction

  // One clock: push expectation, compare at negedge, advance model at posedge
  task automatic cycle();
    exp_t e, a;
    int   n_cnt;
    bit   n_pend, n_infl;
    exp_q.push_back(model());
    @(negedge clk);
    a.c.pc_en         = bus_if.pc_en;
    a.c.if_id_en      = bus_if.if_id_en;
    a.c.if_id_flush   = bus_if.if_id_flush;
    a.c.id_ex_en      = bus_if.id_ex_en;
    a.c.id_ex_bubble  = bus_if.id_ex_bubble;
    a.c.ex_mem_en     = bus_if.ex_mem_en;
    a.c.ex_mem_bubble = bus_if.ex_mem_bubble;
    a.c.pc_sel        = bus_if.pc_sel;
    a.c.int_inject    = bus_if.int_inject;
    a.c.int_ack       = bus_if.int_ack;
    a.mws             = bus_if.mem_word_sel;
    obs = a;
    e = exp_q.pop_front();
    chk("pc_en",         32'(a.c.pc_en),         32'(e.c.pc_en));
    chk("if_id_en",      32'(a.c.if_id_en),      32'(e.c.if_id_en));
    chk("if_id_flush",   32'(a.c.if_id_flush),   32'(e.c.if_id_flush));
    chk("id_ex_en",      32'(a.c.id_ex_en),      32'(e.c.id_ex_en));
    chk("id_ex_bubble",  32'(a.c.id_ex_bubble),  32'(e.c.id_ex_bubble));
    chk("ex_mem_en",     32'(a.c.ex_mem_en),     32'(e.c.ex_mem_en));
    chk("ex_mem_bubble", 32'(a.c.ex_mem_bubble), 32'(e.c.ex_mem_bubble));
    chk("pc_sel",        32'(a.c.pc_sel),        32'(e.c.pc_sel));
    chk("int_inject",    32'(a.c.int_inject),    32'(e.c.int_inject));
    chk("int_ack",       32'(a.c.int_ack),       32'(e.c.int_ack));
    chk("mem_word_sel",  32'(a.mws),             32'(e.mws));
    n_cnt = m_cnt; n_pend = m_pend; n_infl = m_infl;
    if (rst) begin
      n_cnt = 0; n_pend = 0; n_infl = 0;
    end else begin
      if (bus_if.mem_stack_pc) n_cnt = (m_cnt == SW - 1) ? 0 : m_cnt + 1;
      if (e.c.int_ack) begin
        n_pend = 0; n_infl = 1;
      end else if (bus_if.int_req && !m_pend && !m_infl) begin
        n_pend = 1;
      end
      if (bus_if.mem_stack_pc && m_cnt == SW - 1 && bus_if.mem_stack_flg && m_infl) n_infl = 0;
    end
    @(posedge clk);
    m_cnt = n_cnt; m_pend = n_pend; m_infl = n_infl;
    #1;
  endtask

  task automatic idle();
    bus_if.id_src1_addr = 0; bus_if.id_src1_used = 0;
    bus_if.id_src2_addr = 0; bus_if.id_src2_used = 0;
    bus_if.ex_mr = 0; bus_if.ex_wb = 0; bus_if.ex_wb_addr = 0;
    bus_if.ex_taken_jump = 0; bus_if.mem_stack_pc = 0;
    bus_if.mem_stack_flg = 0; bus_if.mem_jwsp = 0; bus_if.int_req = 0;
  endtask

  task automatic set_load_use(input logic [2:0] a);
    bus_if.ex_mr = 1; bus_if.ex_wb = 1; bus_if.ex_wb_addr = 3;
    bus_if.id_src2_addr = a; bus_if.id_src2_used = 1;
  endtask

  initial begin
    rst = 1; idle();
    @(posedge clk); #1;

    // reset, then release
    cycle(); cycle();
    chk("rst_flush", 32'(obs.c.if_id_flush), 1);
    chk("rst_bub",   32'(obs.c.ex_mem_bubble), 1);
    chk("rst_sel",   32'(obs.c.pc_sel), 0);
    chk("rst_inj",   32'(obs.c.int_inject), 0);
    rst = 0; cycle();
    chk("rel_pc_en", 32'(obs.c.pc_en), 1);
    chk("rel_bub",   32'(obs.c.id_ex_bubble), 0);
    chk("rel_mws",   32'(obs.mws), 0);

    // load-use on src2, then a non-matching address
    set_load_use(3); cycle();
    chk("lu_pc_en",  32'(obs.c.pc_en), 0);
    chk("lu_ifid",   32'(obs.c.if_id_en), 0);
    chk("lu_bub",    32'(obs.c.id_ex_bubble), 1);
    idle(); set_load_use(5); cycle();
    chk("nolu_pc_en", 32'(obs.c.pc_en), 1);
    idle(); bus_if.ex_mr = 1; bus_if.ex_wb = 1; bus_if.ex_wb_addr = 6;
    bus_if.id_src1_addr = 6; bus_if.id_src1_used = 1; cycle();
    chk("lu1_bub",   32'(obs.c.id_ex_bubble), 1);
    idle();

    // two-word stack access
    bus_if.mem_stack_pc = 1; cycle();
    chk("st0_idex",  32'(obs.c.id_ex_en), 0);
    chk("st0_exmem", 32'(obs.c.ex_mem_en), 0);
    chk("st0_embub", 32'(obs.c.ex_mem_bubble), 0);
    chk("st0_mws",   32'(obs.mws), 0);
    cycle();
    chk("st1_pc_en", 32'(obs.c.pc_en), 1);
    chk("st1_mws",   32'(obs.mws), 1);
    idle(); cycle();
    chk("st2_mws",   32'(obs.mws), 0);

    // RET: jump in the frozen cycle is ignored, last word redirects from memory
    bus_if.mem_stack_pc = 1; bus_if.mem_jwsp = 1; bus_if.ex_taken_jump = 1; cycle();
    chk("ret0_sel",   32'(obs.c.pc_sel), 0);
    chk("ret0_flush", 32'(obs.c.if_id_flush), 0);
    bus_if.ex_taken_jump = 0; cycle();
    chk("ret1_sel",   32'(obs.c.pc_sel), 2);
    chk("ret1_flush", 32'(obs.c.if_id_flush), 1);
    chk("ret1_embub", 32'(obs.c.ex_mem_bubble), 1);
    idle();

    // interrupt raised during a load-use stall
    set_load_use(3); bus_if.int_req = 1; cycle();
    chk("int_stall_inj", 32'(obs.c.int_inject), 0);
    idle(); cycle();
    chk("int_inj",   32'(obs.c.int_inject), 1);
    chk("int_ack",   32'(obs.c.int_ack), 1);
    chk("int_pc_en", 32'(obs.c.pc_en), 0);
    bus_if.int_req = 1; cycle();
    bus_if.int_req = 0; cycle();
    chk("int_drop",  32'(obs.c.int_inject), 0);
    bus_if.mem_stack_pc = 1; bus_if.mem_stack_flg = 1; cycle(); cycle();
    idle(); bus_if.int_req = 1; cycle();
    bus_if.int_req = 0; cycle();
    chk("int_again", 32'(obs.c.int_inject), 1);
    bus_if.mem_stack_pc = 1; bus_if.mem_stack_flg = 1; cycle(); cycle();
    idle();

    // jump beats load-use
    set_load_use(3); bus_if.ex_taken_jump = 1; cycle();
    chk("jl_sel",   32'(obs.c.pc_sel), 1);
    chk("jl_flush", 32'(obs.c.if_id_flush), 1);
    chk("jl_pc_en", 32'(obs.c.pc_en), 1);
    idle();

    // reset in the middle of a frozen access abandons it
    bus_if.mem_stack_pc = 1; cycle();
    rst = 1; cycle();
    chk("rstmid_mws", 32'(obs.mws), 0);
    rst = 0; cycle();
    chk("rstmid_frz", 32'(obs.c.pc_en), 0);
    cycle(); idle();

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst                  = ($urandom_range(0, 39) == 0);
      bus_if.id_src1_addr  = 3'($urandom_range(0, 3));
      bus_if.id_src1_used  = 1'($urandom);
      bus_if.id_src2_addr  = 3'($urandom_range(0, 3));
      bus_if.id_src2_used  = 1'($urandom);
      bus_if.ex_mr         = 1'($urandom);
      bus_if.ex_wb         = 1'($urandom);
      bus_if.ex_wb_addr    = 3'($urandom_range(0, 3));
      bus_if.ex_taken_jump = ($urandom_range(0, 3) == 0);
      bus_if.mem_stack_pc  = ($urandom_range(0, 3) == 0);
      bus_if.mem_stack_flg = 1'($urandom);
      bus_if.mem_jwsp      = 1'($urandom);
      bus_if.int_req       = ($urandom_range(0, 5) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
